// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT,
    ST_DRAIN,
    ST_ABORT
  } state_t;

  localparam int unsigned DEF_N_LOAD   = 8;
  localparam int unsigned DEF_N_RES    = 4;
  localparam logic [7:0]  DEF_RES_BASE = 8'd32;
  localparam logic [11:0] DEF_TIMEOUT  = 12'd4095;

endpackage

// File: rtl/run_wdog.sv
// WAIT-phase cycle counter with terminal-count compare.
module run_wdog
  import run_ctrl_pkg::*;
#(
  parameter logic [11:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [11:0] r_cnt;

  // Counter: cleared on entry to WAIT, advances every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset)    r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en)  r_cnt <= r_cnt + 12'd1;
  end

  // The parent qualifies this with its WAIT state.
  assign expired = (r_cnt == TIMEOUT);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: load operands, launch the core, wait for done, drain results.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned N_LOAD   = DEF_N_LOAD,
  parameter int unsigned N_RES    = DEF_N_RES,
  parameter logic [7:0]  RES_BASE = DEF_RES_BASE,
  parameter logic [11:0] TIMEOUT  = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_dat,
  input  logic [7:0] mem_rd_dat,
  output logic       core_req,
  input  logic       core_done,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic       busy,
  output logic       timeout
);

  // Addresses of the final load / drain beats (modulo 256).
  localparam logic [7:0] LAST_LD  = 8'(N_LOAD - 1);
  localparam logic [7:0] LAST_RES = 8'(RES_BASE + N_RES - 1);

  state_t     r_state, w_next;
  logic [7:0] r_addr;
  logic       r_armed;
  logic       r_timeout;
  logic       w_done_ok;
  logic       w_expired;
  logic       w_wd_clr;
  logic       w_wd_en;

  assign w_wd_clr  = (r_state == ST_LAUNCH);
  assign w_wd_en   = (r_state == ST_WAIT);
  assign w_done_ok = (r_state == ST_WAIT) && core_done && r_armed;

  run_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    ld_ready  = 1'b0;
    mem_wr_en = 1'b0;
    core_req  = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = (N_LOAD == 0) ? ST_LAUNCH : ST_LOAD;
      ST_LOAD: begin
        ld_ready  = 1'b1;
        mem_wr_en = ld_valid;
        if (ld_valid && (r_addr == LAST_LD)) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        core_req = 1'b1;
        w_next   = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done_ok)      w_next = ST_DRAIN;
        else if (w_expired) w_next = ST_ABORT;
      end
      ST_DRAIN: begin
        res_valid = 1'b1;
        if (res_ready && (r_addr == LAST_RES)) w_next = ST_IDLE;
      end
      ST_ABORT:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    // Reset masks the strobes in the very cycle it is asserted, so a
    // mid-run reset cannot produce one last write or result beat.
    if (reset) begin
      ld_ready  = 1'b0;
      mem_wr_en = 1'b0;
      core_req  = 1'b0;
      res_valid = 1'b0;
    end
  end

  // Address register, done arming and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_armed   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_addr    <= '0;
          r_timeout <= 1'b0;
        end
        ST_LOAD:   if (ld_valid) r_addr <= r_addr + 8'd1;
        ST_LAUNCH: r_armed <= 1'b0;
        ST_WAIT: begin
          if (!core_done) r_armed <= 1'b1;
          if (w_done_ok)      r_addr    <= RES_BASE;
          else if (w_expired) r_timeout <= 1'b1;
        end
        ST_DRAIN:  if (res_ready) r_addr <= r_addr + 8'd1;
        default: ;
      endcase
    end
  end

  assign busy       = !reset && (r_state != ST_IDLE);
  assign mem_addr   = r_addr;
  assign mem_wr_dat = ld_data;
  assign res_data   = mem_rd_dat;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl.
module tb_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, ld_valid, core_done, res_ready;
  logic [7:0] ld_data, mem_rd_dat;
  logic       ld_ready, mem_wr_en, core_req, res_valid, busy, timeout;
  logic [7:0] mem_addr, mem_wr_dat, res_data;

  logic       start_b, ld_valid_b, core_done_b, res_ready_b;
  logic [7:0] ld_data_b, mem_rd_dat_b;
  logic       ld_ready_b, mem_wr_en_b, core_req_b, res_valid_b, busy_b, timeout_b;
  logic [7:0] mem_addr_b, mem_wr_dat_b, res_data_b;

  run_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_dat(mem_wr_dat),
    .mem_rd_dat(mem_rd_dat), .core_req(core_req), .core_done(core_done),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .timeout(timeout)
  );

  run_ctrl #(.N_LOAD(0), .N_RES(4), .RES_BASE(8'd254)) u_wrap (
    .clk(clk), .reset(reset), .start(start_b), .ld_valid(ld_valid_b), .ld_data(ld_data_b),
    .ld_ready(ld_ready_b), .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b), .mem_wr_dat(mem_wr_dat_b),
    .mem_rd_dat(mem_rd_dat_b), .core_req(core_req_b), .core_done(core_done_b),
    .res_valid(res_valid_b), .res_data(res_data_b), .res_ready(res_ready_b),
    .busy(busy_b), .timeout(timeout_b)
  );

  // Data memory model for the main instance; the wrap instance reads a fixed pattern.
  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr, pl_dat;
  assign mem_rd_dat   = mem[mem_addr];
  assign mem_rd_dat_b = 8'hC0 ^ mem_addr_b;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_dat;
    if (pl_en)     mem[pl_addr]  <= pl_dat;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] d; } ev_t;
  ev_t  wq[$];
  ev_t  bq[$];
  int   n_req = 0;
  logic hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #2;
    if (mem_wr_en) wq.push_back('{mem_addr, mem_wr_dat});
    if (res_valid && hold_v) chk("res_hold", {24'd0, res_data}, {24'd0, hold_d});
    if (res_valid && res_ready) bq.push_back('{mem_addr, res_data});
    hold_v = res_valid && !res_ready;
    hold_d = res_data;
    if (core_req) n_req++;
    @(negedge clk);
  endtask

  task automatic pl(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic clear_logs();
    wq.delete(); bq.delete(); n_req = 0;
  endtask

  // Start a run and feed bytes base+i until the launch pulse is seen.
  task automatic load_all(input logic [7:0] base);
    int k;
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (n_req == 0 && k < 30) begin
      ld_valid = (wq.size() < 8);
      ld_data  = 8'(base + wq.size());
      tick(); k++;
    end
    ld_valid = 1'b0;
    chk("load_count", wq.size(), 8);
    chk("launch_seen", n_req, 1);
  endtask

  typedef struct {
    logic st, lv; logic [7:0] ld; logic cd, rr;
    logic busy, rdy, wr; logic [7:0] addr; logic req, rv; logic [7:0] rd;
  } vec_t;
  vec_t tbl[18];

  // Random run: operands, memory results, gaps and done timing are all random.
  // Expected traffic: write i -> (i, b[i]); beat i -> (32+i, rv[i]); one launch.
  task automatic rand_run();
    logic [7:0] b[8];
    logic [7:0] rv[4];
    int cyc, since, sdrop, drop_wait, rise_wait;
    logic dropped, rose, early;
    for (int i = 0; i < 4; i++) begin rv[i] = 8'($urandom); pl(8'(32 + i), rv[i]); end
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    drop_wait = $urandom_range(0, 3);
    rise_wait = $urandom_range(1, 8);
    dropped = 1'b0; rose = 1'b0; early = 1'b0; since = -1; sdrop = 0;
    clear_logs();
    start = 1'b1; tick();
    cyc = 0;
    while (busy && cyc < 400) begin
      ld_valid  = 1'($urandom);
      ld_data   = (wq.size() < 8) ? b[wq.size()] : 8'($urandom);
      start     = 1'($urandom);
      res_ready = 1'($urandom);
      if (n_req > 0) begin
        since++;
        if (!dropped && since >= drop_wait) begin
          core_done = 1'b0; dropped = 1'b1; sdrop = since;
        end else if (dropped && !rose && since >= sdrop + rise_wait) begin
          core_done = 1'b1; rose = 1'b1;
        end
      end
      if (res_valid && !rose) early = 1'b1;
      tick(); cyc++;
    end
    start = 1'b0; ld_valid = 1'b0;
    chk("rnd_bound", cyc < 400, 1);
    chk("rnd_launch", n_req, 1);
    chk("rnd_early_drain", early, 0);
    chk("rnd_timeout", timeout, 0);
    chk("rnd_wr_n", wq.size(), 8);
    for (int i = 0; i < 8 && i < wq.size(); i++)
      chk($sformatf("rnd_wr%0d", i), {wq[i].a, wq[i].d}, {8'(i), b[i]});
    chk("rnd_beat_n", bq.size(), 4);
    for (int i = 0; i < 4 && i < bq.size(); i++)
      chk($sformatf("rnd_beat%0d", i), {bq[i].a, bq[i].d}, {8'(32 + i), rv[i]});
  endtask

  initial begin
    int n, k, seen;
    ev_t wb[$];

    reset = 1'b1; start = 1'b1; ld_valid = 1'b1; ld_data = 8'h55;
    core_done = 1'b0; res_ready = 1'b1;
    start_b = 1'b0; ld_valid_b = 1'b0; ld_data_b = '0; core_done_b = 1'b0; res_ready_b = 1'b0;

    // Reset dominates start/ld_valid.
    repeat (2) @(negedge clk);
    #2;
    chk("rst_outs", {busy, ld_ready, mem_wr_en, core_req, res_valid, timeout}, 6'b0);
    chk("rst_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; ld_valid = 1'b0; res_ready = 1'b0;
    tick();
    chk("rst_idle", busy, 0);

    for (int i = 0; i < 4; i++) pl(8'(32 + i), 8'(8'hA0 + i));
    pl(8'd8, 8'h5A);

    // Table: one full run, cycle by cycle.
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h00};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'(i - 1), 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8,  1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8,  1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd8,  1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd32, 1'b0, 1'b1, 8'hA0};
    for (int i = 0; i < 4; i++)
      tbl[13 + i] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'(32 + i), 1'b0, 1'b1, 8'(8'hA0 + i)};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd36, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st; ld_valid = tbl[i].lv; ld_data = tbl[i].ld;
      core_done = tbl[i].cd; res_ready = tbl[i].rr;
      #2;
      chk($sformatf("tbl%0d_ctl", i), {busy, ld_ready, mem_wr_en, core_req, res_valid},
          {tbl[i].busy, tbl[i].rdy, tbl[i].wr, tbl[i].req, tbl[i].rv});
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      if (tbl[i].wr) chk($sformatf("tbl%0d_wdat", i), mem_wr_dat, tbl[i].ld);
      if (tbl[i].rv) chk($sformatf("tbl%0d_rdat", i), res_data, tbl[i].rd);
      @(negedge clk);
    end
    start = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("mem%0d", i), mem[i], 8'(8'h11 + i));
    chk("mem8_untouched", mem[8], 8'h5A);

    // Stale done held across launch, then a genuine rise; slow consumer.
    core_done = 1'b1;
    load_all(8'h20);
    seen = 0;
    repeat (30) begin if (res_valid) seen++; tick(); end
    chk("stale_done_ignored", seen, 0);
    core_done = 1'b0;
    repeat (20) tick();
    core_done = 1'b1;
    k = 0;
    while (!res_valid && k < 10) begin tick(); k++; end
    chk("rise_latency", k, 1);
    chk("first_res_addr", mem_addr, 32);
    bq.delete();
    n = 0;
    while (busy && n < 40) begin res_ready = 1'(n % 2); tick(); n++; end
    res_ready = 1'b0;
    chk("toggle_beats", bq.size(), 4);
    for (int i = 0; i < 4 && i < bq.size(); i++)
      chk($sformatf("toggle_beat%0d", i), bq[i].d, 8'(8'hA0 + i));
    chk("toggle_idle", busy, 0);

    // Done never rises: abort after the watchdog runs out.
    core_done = 1'b0;
    load_all(8'h40);
    n = 1;
    while (!timeout && n < 5000) begin tick(); n++; end
    chk("timeout_cycles", n, 4097);
    chk("abort_busy", busy, 1);
    tick();
    chk("abort_idle", {busy, timeout}, 2'b01);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_clears_timeout", {busy, timeout}, 2'b10);

    // Reset after three loaded bytes.
    reset = 1'b1; tick(); reset = 1'b0;
    pl(8'd3, 8'h5A);
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin ld_data = 8'(8'h31 + i); tick(); end
    reset = 1'b1; ld_data = 8'h77;
    #2;
    chk("rst_mid_wr", mem_wr_en, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_mid_outs", {busy, ld_ready, mem_wr_en, core_req, res_valid, timeout}, 6'b0);
    chk("rst_mid_addr", mem_addr, 0);
    @(negedge clk);
    ld_valid = 1'b0;
    tick();
    chk("rst_mid_mem2", mem[2], 8'h33);
    chk("rst_mid_mem3", mem[3], 8'h5A);

    // Randomized runs.
    core_done = 1'b1;
    for (int r = 0; r < 20; r++) rand_run();

    // Result region wrapping past address 255, no load phase.
    start_b = 1'b1; @(negedge clk);
    start_b = 1'b0; res_ready_b = 1'b1;
    #2;
    chk("wrap_launch", {core_req_b, ld_ready_b, mem_wr_en_b, timeout_b}, 4'b1000);
    chk("wrap_wdat", mem_wr_dat_b, ld_data_b);
    repeat (2) @(negedge clk);
    core_done_b = 1'b1;
    n = 0;
    while (n < 30) begin
      #2;
      if (res_valid_b) wb.push_back('{mem_addr_b, res_data_b});
      @(negedge clk); n++;
      if (!busy_b) break;
    end
    chk("wrap_beats", wb.size(), 4);
    for (int i = 0; i < 4 && i < wb.size(); i++)
      chk($sformatf("wrap_beat%0d", i), {wb[i].a, wb[i].d},
          {8'(254 + i), 8'hC0 ^ 8'(254 + i)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
